// File: rtl/ysyx_22050612_mdu.sv
// ============================================================================
// Module   : ysyx_22050612_mdu
// Purpose  : Iterative radix-2 multiply/divide unit for RV64M/RV32M (+W ops).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22050612_mdu #(
    parameter int XLEN = 64,
    parameter int W_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam bit            W_EFF     = (XLEN == 64) && (W_EN != 0);
    localparam int            CW        = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(31);
    localparam int            WSHIFT    = XLEN - 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Request decode, evaluated on the live inputs in IDLE.
    logic            w_word;
    logic [2:0]      w_op;
    logic            w_a_sgn, w_b_sgn;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_min, w_dvd_sx;
    logic            w_div0, w_ovf;
    logic [XLEN-1:0] w_special;

    assign w_word  = word_i & W_EFF;
    assign w_op    = (w_word && (op_i inside {3'd1, 3'd2, 3'd3})) ? 3'd0 : op_i;
    assign w_a_sgn = w_op inside {3'd1, 3'd2, 3'd4, 3'd6};
    assign w_b_sgn = w_op inside {3'd1, 3'd4, 3'd6};
    assign w_a_ext = w_word ? (w_a_sgn ? sext32(src1_i[31:0]) : zext32(src1_i[31:0])) : src1_i;
    assign w_b_ext = w_word ? (w_b_sgn ? sext32(src2_i[31:0]) : zext32(src2_i[31:0])) : src2_i;
    assign w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
    assign w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_min    = w_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_dvd_sx = w_word ? sext32(src1_i[31:0]) : src1_i;
    assign w_div0   = w_op[2] && (w_b_ext == '0);
    assign w_ovf    = w_op[2] && !w_op[0] && (w_a_ext == w_min) && (w_b_ext == '1);
    assign w_special = w_div0 ? (w_op[1] ? w_dvd_sx : '1)
                              : (w_op[1] ? '0 : w_a_ext);

    // One radix-2 step: operand bits are consumed MSB-first from opb.
    logic [2*XLEN-1:0] w_addend, w_acc_mul;
    logic [XLEN:0]     w_rsh, w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_next, w_quo_next;

    assign w_addend   = opb_q[XLEN-1] ? {{XLEN{1'b0}}, opa_q} : '0;
    assign w_acc_mul  = (acc_q << 1) + w_addend;
    assign w_rsh      = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
    assign w_diff     = w_rsh - {1'b0, opa_q};
    assign w_ge       = !w_diff[XLEN];
    assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
    assign w_quo_next = {opb_q[XLEN-2:0], w_ge};

    // Sign fix-up and result selection for the final step.
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res, w_quo, w_rem, w_raw, w_final;
    logic              w_last;

    assign w_prod    = (neg_a_q ^ neg_b_q) ? -w_acc_mul : w_acc_mul;
    assign w_mul_res = (op_q == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_quo     = (neg_a_q ^ neg_b_q) ? -w_quo_next : w_quo_next;
    assign w_rem     = neg_a_q ? -w_rem_next : w_rem_next;
    assign w_raw     = op_q[2] ? (op_q[1] ? w_rem : w_quo) : w_mul_res;
    assign w_final   = word_q ? sext32(w_raw[31:0]) : w_raw;
    assign w_last    = (cnt_q == (word_q ? LAST_WORD : LAST_FULL));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    op_d    = w_op;
                    word_d  = w_word;
                    neg_a_d = w_a_neg;
                    neg_b_d = w_b_neg;
                    cnt_d   = '0;
                    acc_d   = '0;
                    // Multiply: opa = multiplicand, opb = multiplier.
                    // Divide:   opa = divisor,      opb = dividend/quotient.
                    opa_d   = w_op[2] ? w_b_mag : w_a_mag;
                    opb_d   = (w_op[2] ? w_a_mag : w_b_mag) << (w_word ? WSHIFT : 0);
                    if (w_div0 || w_ovf) begin
                        result_d = w_special;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    opb_d = w_quo_next;
                    acc_d = {{XLEN{1'b0}}, w_rem_next};
                end else begin
                    opb_d = opb_q << 1;
                    acc_d = w_acc_mul;
                end
                if (w_last) begin
                    result_d = w_final;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050612_mdu.sv
// ============================================================================
// Module   : tb_ysyx_22050612_mdu
// Purpose  : Self-checking bench for ysyx_22050612_mdu against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050612_mdu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_22050612_mdu #(.XLEN(64), .W_EN(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .word_i     (word),
        .src1_i     (src1),
        .src2_i     (src2),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // RISC-V M-extension semantics in plain arithmetic; also yields expected latency.
    task automatic ref_mdu(input logic [2:0] op_in, input logic w, input logic [63:0] a,
                           input logic [63:0] b, output logic [63:0] res, output int lat);
        logic [2:0]           o;
        logic signed [129:0]  sa, sb, p;
        int                   x, y;
        logic [31:0]          ux, uy;
        longint               lx, ly;
        o   = op_in;
        if (w && o >= 3'd1 && o <= 3'd3) o = 3'd0;
        lat = w ? 33 : 65;
        if (!o[2]) begin
            sa  = (o == 3'd1 || o == 3'd2) ? {{66{a[63]}}, a} : {66'b0, a};
            sb  = (o == 3'd1) ? {{66{b[63]}}, b} : {66'b0, b};
            p   = sa * sb;
            res = (o == 3'd0) ? p[63:0] : p[127:64];
            if (w) res = sx32(p[31:0]);
        end else if (w) begin
            x = int'(a[31:0]); y = int'(b[31:0]);
            ux = a[31:0]; uy = b[31:0];
            if (!o[0]) begin
                if (y == 0) begin
                    res = o[1] ? sx32(32'(x)) : '1; lat = 1;
                end else if (x == 32'sh8000_0000 && y == -1) begin
                    res = o[1] ? 64'd0 : sx32(32'(x)); lat = 1;
                end else begin
                    res = sx32(32'(o[1] ? x % y : x / y));
                end
            end else begin
                if (uy == 0) begin
                    res = o[1] ? sx32(ux) : '1; lat = 1;
                end else begin
                    res = sx32(o[1] ? ux % uy : ux / uy);
                end
            end
        end else begin
            lx = longint'(a); ly = longint'(b);
            if (!o[0]) begin
                if (ly == 0) begin
                    res = o[1] ? a : '1; lat = 1;
                end else if (a == 64'h8000_0000_0000_0000 && ly == -1) begin
                    res = o[1] ? 64'd0 : a; lat = 1;
                end else begin
                    res = 64'(o[1] ? lx % ly : lx / ly);
                end
            end else begin
                if (b == 0) begin
                    res = o[1] ? a : '1; lat = 1;
                end else begin
                    res = o[1] ? a % b : a / b;
                end
            end
        end
    endtask

    // Issue one request, measure latency, optionally stall in DONE, then retire it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp;
        int          exp_lat, lat, tries;
        ref_mdu(o, w, a, b, exp, exp_lat);
        out_ready = 1'b0;
        tries = 0;
        @(negedge clk);
        while (!in_ready && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; word = w; src1 = a; src2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1 = {$urandom(), $urandom()};
        src2 = {$urandom(), $urandom()};
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            check_val({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_val({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            check_val({tag, "_hold_result"}, result, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_retire_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_retire_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Start an op, then abort it after `cycles` CALC cycles by flush or reset.
    task automatic abort_op(input string tag, input bit use_reset, input int cycles);
        int seen;
        seen = 0;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd5; word = 1'b0; src1 = 64'd1000; src2 = 64'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; flush = 1'b0;
        check_val({tag, "_idle"}, 64'(in_ready), 64'd1);
        for (int i = 0; i < 80; i++) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check_val({tag, "_no_valid"}, 64'(seen), 64'd0);
        if (use_reset) check_val({tag, "_result_cleared"}, result, 64'd0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return {32'h0, $urandom()};
            5:       return {$urandom(), 32'h8000_0000};
            6:       return 64'($urandom_range(0, 50));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out_valid", 64'(out_valid), 64'd0);
        check_val("reset_in_ready", 64'(in_ready), 64'd1);
        check_val("reset_result", result, 64'd0);
        rst_n = 1'b1;

        run_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("mulhu", 3'd3, 1'b0, '1, '1, 0);
        run_op("mulh", 3'd1, 1'b0, '1, '1, 0);
        run_op("mulhsu", 3'd2, 1'b0, '1, '1, 0);
        run_op("div0", 3'd4, 1'b0, 64'd100, 64'd0, 0);
        run_op("rem0", 3'd6, 1'b0, 64'd100, 64'd0, 0);
        run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op("divw", 3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 0);
        run_op("remw", 3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 0);
        run_op("divuw", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 0);
        run_op("backpressure", 3'd7, 1'b0, 64'd12345, 64'd100, 10);

        abort_op("flush", 1'b0, 20);
        abort_op("reset", 1'b1, 30);
        run_op("divu_after", 3'd5, 1'b0, 64'd17, 64'd5, 0);

        for (int k = 0; k < 150; k++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   pick_operand(), pick_operand(), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
